// File: rtl/mor1kx_dcache_mem_responder.sv
// mor1kx_dcache_mem_responder
//
// Memory-side responder for the data-cache bus. It answers each beat of the
// req/we/adr/bsel/dat protocol with exactly one ack or err cycle. The beat is
// served from an internal synchronous word RAM. Non-sequential accesses
// insert FIRST_WAIT wait cycles. Addresses outside the RAM window get err.
//
// Optional feature (macro MOR1KX_DCACHE_MEM_RESPONDER_BURST_EN):
//   A read that directly follows an acked read is a refill beat when its
//   address is the wrapping increment of the previous one. Such a beat is
//   answered with zero wait states. When the macro is undefined, every beat
//   pays FIRST_WAIT.
//
// Parameters:
//   MEM_ADDR_WIDTH  byte address width of the RAM window (2^(W-2) words)
//   MEM_BASE        byte base of the window, aligned to 2^MEM_ADDR_WIDTH
//   FIRST_WAIT      wait cycles on a non-sequential access (0..15)
//   BLOCK_WIDTH     cache block width used for burst wrap detection
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-low reset
//   dbus_req_i   request, held until ack/err
//   dbus_we_i    1 = write
//   dbus_adr_i   byte address (bits [1:0] ignored)
//   dbus_bsel_i  byte selects for writes
//   dbus_dat_i   write data
//   dbus_ack_o   one-cycle beat acknowledge
//   dbus_err_o   one-cycle error response
//   dbus_dat_o   read data, valid in the ack cycle, zero otherwise
module mor1kx_dcache_mem_responder #(
  parameter int          MEM_ADDR_WIDTH = 12,
  parameter logic [31:0] MEM_BASE       = 32'h0,
  parameter int          FIRST_WAIT     = 2,
  parameter int          BLOCK_WIDTH    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_req_i,
  input  logic        dbus_we_i,
  input  logic [31:0] dbus_adr_i,
  input  logic [3:0]  dbus_bsel_i,
  input  logic [31:0] dbus_dat_i,
  output logic        dbus_ack_o,
  output logic        dbus_err_o,
  output logic [31:0] dbus_dat_o
);

  localparam int IDX_W = MEM_ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam logic [3:0] WAIT_LOAD = (FIRST_WAIT > 0) ? 4'(FIRST_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic             err_r;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_r;
  logic             we_r;
  logic [3:0]       bsel_r;
  logic [31:0]      wdat_r;

  logic [31:0]      mem [WORDS];
  logic [31:0]      rdata;
  logic [IDX_W-1:0] rd_idx;
  logic             in_window;
  logic             fast;
  logic             unused_adr_bits;

  assign unused_adr_bits = &{1'b0, dbus_adr_i[1:0]};

  // Window check only needs the bits above the window, since MEM_BASE is
  // aligned to the window size.
  assign in_window = (dbus_adr_i[31:MEM_ADDR_WIDTH] == MEM_BASE[31:MEM_ADDR_WIDTH]);

`ifdef MOR1KX_DCACHE_MEM_RESPONDER_BURST_EN
  logic             seq;
  logic [IDX_W-1:0] last_idx;

  // Both addresses involved in the fast-path compare are inside the window.
  // The upper bits therefore agree, and only the word index is tracked.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = idx;
    r[BLOCK_WIDTH-3:0] = idx[BLOCK_WIDTH-3:0] + 1'b1;
    return r;
  endfunction

  assign fast = seq && !dbus_we_i &&
                (dbus_adr_i[MEM_ADDR_WIDTH-1:2] == wrap_inc(last_idx));

  // The flag is only consulted in the IDLE cycle right after an acked read.
  // Any other IDLE cycle or response drops it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seq <= 1'b0;
    end else if (state == RESP) begin
      seq      <= !err_r && !we_r;
      last_idx <= idx_r;
    end else if (state == IDLE) begin
      seq <= 1'b0;
    end
  end
`else
  assign fast = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      err_r <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dbus_req_i) begin
            if (!in_window) begin
              err_r <= 1'b1;
              state <= RESP;
            end else if (fast || FIRST_WAIT == 0) begin
              err_r <= 1'b0;
              state <= RESP;
            end else begin
              err_r <= 1'b0;
              cnt   <= WAIT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // An abort wins over counter expiry.
          if (!dbus_req_i)    state <= IDLE;
          else if (cnt == 0)  state <= RESP;
          else                cnt   <= cnt - 4'd1;
        end
        RESP: begin
          err_r <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat capture
  always_ff @(posedge clk) begin
    if (state == IDLE && dbus_req_i) begin
      idx_r  <= dbus_adr_i[MEM_ADDR_WIDTH-1:2];
      we_r   <= dbus_we_i;
      bsel_r <= dbus_bsel_i;
      wdat_r <= dbus_dat_i;
    end
  end

  // In IDLE, the RAM reads the live address, so a zero-wait beat has its
  // data ready in RESP. A write commits on the same edge that leaves RESP.
  // The following IDLE read therefore already sees the new data.
  assign rd_idx = (state == IDLE) ? dbus_adr_i[MEM_ADDR_WIDTH-1:2] : idx_r;

  always_ff @(posedge clk) begin
    rdata <= mem[rd_idx];
    if (rst && state == RESP && !err_r && we_r) begin
      for (int b = 0; b < 4; b++) begin
        if (bsel_r[b]) mem[idx_r][8*b +: 8] <= wdat_r[8*b +: 8];
      end
    end
  end

  assign dbus_ack_o = (state == RESP) && !err_r;
  assign dbus_err_o = (state == RESP) && err_r;
  assign dbus_dat_o = dbus_ack_o ? rdata : 32'h0;

endmodule

// File: tb/tb_mor1kx_dcache_mem_responder.sv
// Testbench for mor1kx_dcache_mem_responder with default parameters
// (MEM_ADDR_WIDTH=12, MEM_BASE=0, FIRST_WAIT=2, BLOCK_WIDTH=5).
// The latency of a refill beat depends on MOR1KX_DCACHE_MEM_RESPONDER_BURST_EN.
module tb_mor1kx_dcache_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  bsel;
  logic [31:0] wdat;
  logic        ack;
  logic        err;
  logic [31:0] rdat;

`ifdef MOR1KX_DCACHE_MEM_RESPONDER_BURST_EN
  localparam int BURST_LAT = 1;
`else
  localparam int BURST_LAT = 3;
`endif

  mor1kx_dcache_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .dbus_req_i  (req),
    .dbus_we_i   (we),
    .dbus_adr_i  (adr),
    .dbus_bsel_i (bsel),
    .dbus_dat_i  (wdat),
    .dbus_ack_o  (ack),
    .dbus_err_o  (err),
    .dbus_dat_o  (rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A response must never have ack and err together, and it must never
  // last two cycles.
  logic prev_resp = 1'b0;
  always @(negedge clk) begin
    if (rst && (ack || err)) begin
      check("ack_err_exclusive_single", {30'd0, ack && err, prev_resp}, 32'd0);
    end
    prev_resp = ack || err;
  end

  // One beat: inputs are driven in the IDLE cycle. The task returns at the
  // negedge of the response cycle, with the request still held.
  task automatic beat(input logic b_we, input logic [31:0] b_adr, input logic [3:0] b_bsel,
                      input logic [31:0] b_dat, output int lat, output logic e,
                      output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = b_we; adr = b_adr; bsel = b_bsel; wdat = b_dat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ack || err) && lat < 40);
    e  = err;
    rd = rdat;
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  bsel;
    logic [31:0] dat;
    logic        exp_err;
    int          exp_lat;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [16];
  logic [31:0] refill_order [8];

  int          lat;
  logic        e;
  logic [31:0] rd;
  int          seen;

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0040, 4'hF, 32'hDEADBEEF, 1'b0, 3, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 32'h0000_0080, 4'hF, 32'h11223344, 1'b0, 3, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0000A5A5, 1'b0, 3, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h12345678, 1'b0, 3, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_0024, 4'hF, 32'h24242424, 1'b0, 3, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D, 1'b0, 3, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,        1'b0, 3, 1'b1, 32'hDEADBEEF};
    vt[7]  = '{1'b1, 32'h0000_0080, 4'h2, 32'hAABBCCDD, 1'b0, 3, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 32'h0000_0080, 4'hF, 32'h0,        1'b0, 3, 1'b1, 32'h1122CC44};
    vt[9]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 1'b1, 1, 1'b1, 32'h0};
    vt[10] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,        1'b0, 3, 1'b1, 32'h0000A5A5};
    vt[11] = '{1'b0, 32'h0000_2000, 4'hF, 32'h0,        1'b1, 1, 1'b1, 32'h0};
    vt[12] = '{1'b1, 32'h0000_0FFC, 4'h9, 32'h11223344, 1'b0, 3, 1'b0, 32'h0};
    vt[13] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,        1'b0, 3, 1'b1, 32'h11FEF044};
    vt[14] = '{1'b0, 32'h0000_0043, 4'h0, 32'h0,        1'b0, 3, 1'b1, 32'hDEADBEEF};
    vt[15] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,        1'b1, 1, 1'b1, 32'h0};

    refill_order = '{32'h14, 32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};

    rst = 1'b0; req = 1'b0; we = 1'b0; adr = 32'h0; bsel = 4'h0; wdat = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_dat", rdat, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      beat(vt[i].we, vt[i].adr, vt[i].bsel, vt[i].dat, lat, e, rd);
      check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
      check($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      if (vt[i].chk_rd) check($sformatf("vec%0d_dat", i), rd, vt[i].exp_rd);
      idle();
    end

    // Write followed immediately by a read of the same word
    beat(1'b1, 32'h60, 4'hF, 32'h55AA55AA, lat, e, rd);
    check("wr_rd_wlat", lat, 3);
    beat(1'b0, 32'h60, 4'hF, 32'h0, lat, e, rd);
    check("wr_rd_rlat", lat, 3);
    check("wr_rd_dat", rd, 32'h55AA55AA);
    idle();

    // Refill of block 0x00..0x1C, starting at the critical word 0x14
    for (int k = 0; k < 8; k++) beat(1'b1, 32'(k * 4), 4'hF, 32'h1000_0000 + 32'(k), lat, e, rd);
    idle();
    for (int k = 0; k < 8; k++) begin
      beat(1'b0, refill_order[k], 4'hF, 32'h0, lat, e, rd);
      check($sformatf("refill%0d_lat", k), lat, (k == 0) ? 3 : BURST_LAT);
      check($sformatf("refill%0d_dat", k), rd, 32'h1000_0000 + (refill_order[k] >> 2));
      check($sformatf("refill%0d_err", k), {31'd0, e}, 32'd0);
    end
    idle();

    // Back-to-back reads: non-wrap successor is slow, wrap successor is fast.
    // A write is never fast.
    beat(1'b0, 32'h40, 4'hF, 32'h0, lat, e, rd);
    check("nseq_a_lat", lat, 3);
    beat(1'b0, 32'h48, 4'hF, 32'h0, lat, e, rd);
    check("nseq_b_lat", lat, 3);
    beat(1'b0, 32'h4C, 4'hF, 32'h0, lat, e, rd);
    check("seq_c_lat", lat, BURST_LAT);
    beat(1'b1, 32'h50, 4'hF, 32'h50505050, lat, e, rd);
    check("seq_write_lat", lat, 3);
    idle();

    // Crossing the window top right after a read gives err.
    beat(1'b0, 32'hFFC, 4'hF, 32'h0, lat, e, rd);
    check("top_rd_dat", rd, 32'h11FEF044);
    beat(1'b0, 32'h1000, 4'hF, 32'h0, lat, e, rd);
    check("top_cross_err", {31'd0, e}, 32'd1);
    check("top_cross_lat", lat, 1);
    check("top_cross_dat", rd, 32'h0);
    idle();

    // Abort: a write is sampled, then req drops during WAIT.
    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'h20; bsel = 4'hF; wdat = 32'hDEAD0000;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack || err) seen++;
    end
    check("abort_no_resp", seen, 0);
    beat(1'b0, 32'h24, 4'hF, 32'h0, lat, e, rd);
    check("abort_next_lat", lat, 3);
    check("abort_next_dat", rd, 32'h24242424);
    idle();
    beat(1'b0, 32'h20, 4'hF, 32'h0, lat, e, rd);
    check("abort_mem_kept", rd, 32'h12345678);
    idle();

    // Reset in the last WAIT cycle, which would otherwise lead to RESP.
    @(negedge clk);
    req = 1'b1; we = 1'b0; adr = 32'h40; bsel = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_ack", {31'd0, ack}, 32'd0);
    check("rst_wait_err", {31'd0, err}, 32'd0);
    check("rst_wait_dat", rdat, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Reset right after an acked read clears the sequential flag.
    beat(1'b0, 32'h40, 4'hF, 32'h0, lat, e, rd);
    check("rst_seq_pre_dat", rd, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b0; req = 1'b1; we = 1'b0; adr = 32'h44;
    @(negedge clk);
    rst = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ack || err) && lat < 40);
    check("rst_seq_lat", lat, 3);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mor1kx_dcache_mem_responder.md
# mor1kx_dcache_mem_responder

Memory-side responder for the data-cache bus: it answers the req/we/adr/bsel/dat initiator protocol driven by the data cache, with a single ack or err per beat. It is backed by an internal synchronous word RAM and inserts programmable wait states on random accesses. It recognises wrapping refill bursts. It sits between the data cache and on-chip RAM, and serves as the bench memory model for cache verification.

## Interface
- MEM_ADDR_WIDTH, 12, byte address width of the RAM window; holds 2^(MEM_ADDR_WIDTH-2) 32-bit words
- MEM_BASE, 32'h0, byte base address of the window; must be aligned to 2^MEM_ADDR_WIDTH
- FIRST_WAIT, 2, wait cycles inserted on a non-sequential access (0..15)
- BLOCK_WIDTH, 5, cache block width for burst wrap detection (4 or 5)

- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- dbus_req_i  input  1  request; held by initiator until ack/err
- dbus_we_i  input  1  1 = write
- dbus_adr_i  input  32  byte address; bits [1:0] ignored
- dbus_bsel_i  input  4  byte selects for writes; ignored on reads
- dbus_dat_i  input  32  write data
- dbus_ack_o  output  1  one-cycle beat acknowledge
- dbus_err_o  output  1  one-cycle error response, mutually exclusive with ack
- dbus_dat_o  output  32  read data, valid only in an ack cycle

## Operation
- The FSM has three states: IDLE, WAIT and RESP. Reset (rst=0) forces IDLE, with ack=0, err=0, dat_o=0, and the sequential flag cleared. RAM contents are not reset.
- Outputs are decoded from the registered state: ack = (RESP & !err_r), err = (RESP & err_r).
- **IDLE**, when req=1 is sampled in cycle T:
  - Capture adr, we, bsel and dat.
  - If the address is outside [MEM_BASE, MEM_BASE+2^MEM_ADDR_WIDTH): set err_r and go to RESP.
  - Else, if the fast path applies or FIRST_WAIT=0: go to RESP.
  - Else: load the counter with FIRST_WAIT-1 and go to WAIT.
- **WAIT**:
  - If req=0, abort: return to IDLE, with no write and no response.
  - Else, when the counter reaches 0, go to RESP; otherwise decrement.
- **RESP**:
  - Assert ack or err for exactly one cycle, then go to IDLE.
  - A write with ack commits at the end of the RESP cycle, updating only the selected bytes.
  - Error beats never write, and dat_o=0 on err.
- **Sequential flag**:
  - Set on leaving RESP after an acked read.
  - Holds the last address; cleared in every other IDLE cycle or on any other response.
  - The wrap increment replaces adr[BLOCK_WIDTH-1:2] with (adr[BLOCK_WIDTH-1:2]+1) mod 2^(BLOCK_WIDTH-2), keeping the upper bits unchanged.
- **Read data**:
  - The RAM read address is dbus_adr_i in IDLE and the captured address otherwise.
  - dat_o in RESP reflects all writes committed in earlier cycles.
  - Write-then-read to the same word in back-to-back beats returns the new data.
- **Simultaneous and boundary events**:
  - req=1 in the cycle right after ack or err is a new request. The initiator advances its address on ack.
  - Abort and reset take priority over any counter expiry.
  - An address crossing the window top is an error, regardless of burst state.

## Timing
- Non-sequential access sampled in IDLE at T: response at T+1+FIRST_WAIT.
- Error: response at T+1.
- Fast-path read: ack at T+1.
- Minimum beat period is 2 cycles, since IDLE follows every RESP.
- ack and err are never high together and never high for two consecutive cycles.

## Configuration
- Macro: MOR1KX_DCACHE_MEM_RESPONDER_BURST_EN.
- **Defined:** the fast path applies to a read in IDLE with the sequential flag set and adr == wrap_inc(last adr). This is a zero-wait refill beat.
- **Undefined:** the sequential flag logic is removed. Every access uses FIRST_WAIT, so every beat responds at T+1+FIRST_WAIT.

## Test plan
- Read with FIRST_WAIT=2, req at T to 0x40 preloaded with 0xDEADBEEF -> ack and dat_o=0xDEADBEEF at T+3 only; err never asserted.
- Write 0xAABBCCDD with bsel=4'b0010 to 0x80 holding 0x11223344, then read 0x80 -> write ack at T+3; read returns 0x1122CC44.
- 8-beat refill starting at 0x14 (BLOCK_WIDTH=5), with the initiator advancing the address on each ack:
  - Order: 0x14, 0x18, 0x1C, 0x00, 0x04, 0x08, 0x0C, 0x10.
  - With the macro: first ack at T+3, each later ack 2 cycles after the previous one.
  - Without the macro: every beat takes 4 cycles.
- Address 0x1000 with MEM_ADDR_WIDTH=12, MEM_BASE=0 -> err at T+1 and dat_o=0; no ack; a following read of word 0 is unchanged.
- Abort: write to 0x20 sampled at T, req dropped at T+1 -> no ack or err; memory at 0x20 unchanged; next read to 0x24 served with normal latency.
- Reset mid-operation: rst=0 during WAIT -> ack=0, err=0, dat_o=0 next cycle; the read issued after rst=1 is non-sequential (full FIRST_WAIT).
